// File: rtl/ncc_disparity_search.sv
// ncc_disparity_search
//   Window correlation search over NUM_CH candidate disparities. Accumulates
//   sum(f), sum(f^2) and per-channel sum(g), sum(g^2), sum(f*g) over WIN_LEN
//   valid samples. It then scans the channels one per cycle, scoring each as
//   WIN_LEN*sum(fg) - sum(f)*sum(g), and reports the best channel.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   startsig     one-cycle pulse that opens a new window (accepted in IDLE only)
//   startplace   disparity of channel 0, captured with startsig
//   valid        fdata/gdata carry a sample this cycle
//   fdata        left-image sample
//   gdata        right-image samples, channel k at [k*DATA_W +: DATA_W]
//   busy         high from the cycle after an accepted start through done
//   done         one-cycle pulse, best_place/best_score valid
//   best_place   startplace + best channel index (mod 2^PLACE_W)
//   best_score   signed score of the best channel
module ncc_disparity_search #(
  parameter int DATA_W  = 3,
  parameter int NUM_CH  = 4,
  parameter int WIN_LEN = 64,
  parameter int PLACE_W = 8,
  localparam int CNT_W   = $clog2(WIN_LEN + 1),
  localparam int SUM_W   = DATA_W + CNT_W,
  localparam int SUM2_W  = 2 * DATA_W + CNT_W,
  localparam int SCORE_W = 2 * SUM2_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       startsig,
  input  logic [PLACE_W-1:0]         startplace,
  input  logic                       valid,
  input  logic [DATA_W-1:0]          fdata,
  input  logic [NUM_CH*DATA_W-1:0]   gdata,
  output logic                       busy,
  output logic                       done,
  output logic [PLACE_W-1:0]         best_place,
  output logic signed [SCORE_W-1:0]  best_score
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, ACC, EVAL, DONE} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [PLACE_W-1:0]         place_q, place_d;
  logic [SUM_W-1:0]           sum_f_q, sum_f_d;
  logic [SUM2_W-1:0]          sum_f2_q, sum_f2_d;
  logic [SUM_W-1:0]           sum_g_q  [NUM_CH];
  logic [SUM_W-1:0]           sum_g_d  [NUM_CH];
  logic [SUM2_W-1:0]          sum_g2_q [NUM_CH];
  logic [SUM2_W-1:0]          sum_g2_d [NUM_CH];
  logic [SUM2_W-1:0]          sum_fg_q [NUM_CH];
  logic [SUM2_W-1:0]          sum_fg_d [NUM_CH];
  logic [CH_W-1:0]            best_idx_q, best_idx_d;
  logic signed [SCORE_W-1:0]  best_run_q, best_run_d;
  logic [PLACE_W-1:0]         best_place_q, best_place_d;
  logic signed [SCORE_W-1:0]  best_score_q, best_score_d;

  // Per-sample products used during accumulation
  logic [DATA_W-1:0]          g_k     [NUM_CH];
  logic [PROD_W-1:0]          prod_fg [NUM_CH];
  logic [PROD_W-1:0]          prod_gg [NUM_CH];
  logic [PROD_W-1:0]          prod_ff;

  // Shared scoring datapath for the channel selected by ch_q
  logic [SUM_W-1:0]           sel_g;
  logic [SUM2_W-1:0]          sel_fg;
  logic signed [SCORE_W-1:0]  n_fg, f_g, score;
  logic                       take_new;
  logic [CH_W-1:0]            win_idx;
  logic signed [SCORE_W-1:0]  win_score;

  always_comb begin
    prod_ff = {{DATA_W{1'b0}}, fdata} * {{DATA_W{1'b0}}, fdata};
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      g_k[k]     = gdata[k*DATA_W +: DATA_W];
      prod_fg[k] = {{DATA_W{1'b0}}, fdata}  * {{DATA_W{1'b0}}, g_k[k]};
      prod_gg[k] = {{DATA_W{1'b0}}, g_k[k]} * {{DATA_W{1'b0}}, g_k[k]};
    end
  end

  always_comb begin
    sel_g     = sum_g_q[ch_q];
    sel_fg    = sum_fg_q[ch_q];
    n_fg      = $signed(SCORE_W'(WIN_LEN)) * $signed(SCORE_W'(sel_fg));
    f_g       = $signed(SCORE_W'(sum_f_q)) * $signed(SCORE_W'(sel_g));
    score     = n_fg - f_g;
    // Strict greater-than keeps the lower index on ties; channel 0 seeds.
    take_new  = (ch_q == '0) || (score > best_run_q);
    win_idx   = take_new ? ch_q  : best_idx_q;
    win_score = take_new ? score : best_run_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    place_d      = place_q;
    sum_f_d      = sum_f_q;
    sum_f2_d     = sum_f2_q;
    sum_g_d      = sum_g_q;
    sum_g2_d     = sum_g2_q;
    sum_fg_d     = sum_fg_q;
    best_idx_d   = best_idx_q;
    best_run_d   = best_run_q;
    best_place_d = best_place_q;
    best_score_d = best_score_q;

    unique case (state_q)
      IDLE: begin
        if (startsig) begin
          cnt_d    = '0;
          ch_d     = '0;
          place_d  = startplace;
          sum_f_d  = '0;
          sum_f2_d = '0;
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            sum_g_d[k]  = '0;
            sum_g2_d[k] = '0;
            sum_fg_d[k] = '0;
          end
          state_d  = ACC;
        end
      end
      ACC: begin
        if (valid) begin
          sum_f_d  = sum_f_q + SUM_W'(fdata);
          sum_f2_d = sum_f2_q + SUM2_W'(prod_ff);
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            sum_g_d[k]  = sum_g_q[k]  + SUM_W'(g_k[k]);
            sum_g2_d[k] = sum_g2_q[k] + SUM2_W'(prod_gg[k]);
            sum_fg_d[k] = sum_fg_q[k] + SUM2_W'(prod_fg[k]);
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
            ch_d    = '0;
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        best_idx_d = win_idx;
        best_run_d = win_score;
        ch_d       = ch_q + 1'b1;
        // Outputs load on the edge leaving the last channel so they are
        // already valid during the done cycle.
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          best_place_d = place_q + PLACE_W'(win_idx);
          best_score_d = win_score;
          ch_d         = '0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      place_q      <= '0;
      sum_f_q      <= '0;
      sum_f2_q     <= '0;
      sum_g_q      <= '{default: '0};
      sum_g2_q     <= '{default: '0};
      sum_fg_q     <= '{default: '0};
      best_idx_q   <= '0;
      best_run_q   <= '0;
      best_place_q <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      place_q      <= place_d;
      sum_f_q      <= sum_f_d;
      sum_f2_q     <= sum_f2_d;
      sum_g_q      <= sum_g_d;
      sum_g2_q     <= sum_g2_d;
      sum_fg_q     <= sum_fg_d;
      best_idx_q   <= best_idx_d;
      best_run_q   <= best_run_d;
      best_place_q <= best_place_d;
      best_score_q <= best_score_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign best_place = best_place_q;
  assign best_score = best_score_q;

endmodule

// File: tb/tb_ncc_disparity_search.sv
module tb_ncc_disparity_search;

  localparam int DW    = 3;
  localparam int NCH   = 4;
  localparam int PW    = 8;
  localparam int LAT   = NCH + 1;
  localparam int WIN_A = 4;
  localparam int WIN_B = 64;
  localparam int SW_A  = 2 * (2 * DW + $clog2(WIN_A + 1)) + 1;
  localparam int SW_B  = 2 * (2 * DW + $clog2(WIN_B + 1)) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: short window, DUT B: default parameters
  logic                   a_start, a_valid, a_busy, a_done;
  logic [PW-1:0]          a_place, a_bp;
  logic [DW-1:0]          a_f;
  logic [NCH*DW-1:0]      a_g;
  logic signed [SW_A-1:0] a_bs;

  logic                   b_start, b_valid, b_busy, b_done;
  logic [PW-1:0]          b_place, b_bp;
  logic [DW-1:0]          b_f;
  logic [NCH*DW-1:0]      b_g;
  logic signed [SW_B-1:0] b_bs;

  ncc_disparity_search #(.DATA_W(DW), .NUM_CH(NCH), .WIN_LEN(WIN_A), .PLACE_W(PW)) u_dut_a (
    .clk(clk), .rst(rst), .startsig(a_start), .startplace(a_place), .valid(a_valid),
    .fdata(a_f), .gdata(a_g), .busy(a_busy), .done(a_done),
    .best_place(a_bp), .best_score(a_bs)
  );

  ncc_disparity_search #(.DATA_W(DW), .NUM_CH(NCH), .WIN_LEN(WIN_B), .PLACE_W(PW)) u_dut_b (
    .clk(clk), .rst(rst), .startsig(b_start), .startplace(b_place), .valid(b_valid),
    .fdata(b_f), .gdata(b_g), .busy(b_busy), .done(b_done),
    .best_place(b_bp), .best_score(b_bs)
  );

  typedef struct {
    longint place;
    longint score;
    int     t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;
  int done_a = 0;
  int done_b = 0;
  longint held_place_a = 0;
  longint held_score_a = 0;

  int fv[WIN_B];
  int gv[WIN_B][NCH];

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain covariance score per channel, best by strict greater-than
  function automatic void model(input int n, input int place, output longint bp, output longint bs);
    longint sf, sg, sfg, sc;
    bp = 0;
    bs = 0;
    for (int k = 0; k < NCH; k++) begin
      sf = 0; sg = 0; sfg = 0;
      for (int i = 0; i < n; i++) begin
        sf  += fv[i];
        sg  += gv[i][k];
        sfg += fv[i] * gv[i][k];
      end
      sc = n * sfg - sf * sg;
      if (k == 0 || sc > bs) begin
        bs = sc;
        bp = (place + k) % 256;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && a_done) begin
      done_a++;
      if (qa.size() == 0) chk("a_spurious_done", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_place", a_bp, ea.place);
        chk("a_score", $signed(a_bs), ea.score);
        chk("a_latency", cyc - ea.t, LAT);
        chk("a_busy_in_done", a_busy, 1);
        held_place_a = ea.place;
        held_score_a = ea.score;
      end
    end
    if (!rst && b_done) begin
      done_b++;
      if (qb.size() == 0) chk("b_spurious_done", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_place", b_bp, eb.place);
        chk("b_score", $signed(b_bs), eb.score);
        chk("b_latency", cyc - eb.t, LAT);
      end
    end
  end

  task automatic set_scoring_data();
    int f[4]  = '{1, 2, 3, 4};
    int g0[4] = '{1, 2, 3, 4};
    int g1[4] = '{3, 3, 3, 3};
    int g2[4] = '{4, 3, 2, 1};
    int g3[4] = '{2, 4, 6, 7};
    for (int i = 0; i < 4; i++) begin
      fv[i] = f[i];
      gv[i][0] = g0[i]; gv[i][1] = g1[i]; gv[i][2] = g2[i]; gv[i][3] = g3[i];
    end
  endtask

  task automatic a_window(input int place, input int stall, input bit extra_start);
    exp_t   e;
    longint bp, bs;
    int     d0;
    d0 = done_a;
    model(WIN_A, place, bp, bs);
    @(posedge clk); #1;
    a_start = 1'b1;
    a_place = PW'(place);
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < WIN_A; i++) begin
      if (stall > 0 && i > 0) begin
        a_valid = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        chk("a_busy_stall", a_busy, 1);
      end
      a_valid = 1'b1;
      a_f     = DW'(fv[i]);
      for (int k = 0; k < NCH; k++) a_g[k*DW +: DW] = DW'(gv[i][k]);
      a_start = extra_start && (i == 1);
      if (i == 2) begin
        chk("a_hold_place", a_bp, held_place_a);
        chk("a_hold_score", $signed(a_bs), held_score_a);
      end
      if (i == WIN_A - 1) begin
        e.place = bp; e.score = bs; e.t = cyc;
        qa.push_back(e);
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    a_start = 1'b0;
    if (extra_start) begin
      a_start = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      a_start = 1'b0;
    end
    for (int w = 0; w < 20 && qa.size() != 0; w++) begin @(posedge clk); #1; end
    chk("a_done_seen", qa.size(), 0);
    repeat (6) begin @(posedge clk); #1; end
    chk("a_done_count", done_a - d0, 1);
    chk("a_idle_busy", a_busy, 0);
  endtask

  task automatic b_window(input int place, input bit rnd);
    exp_t   e;
    longint bp, bs;
    for (int i = 0; i < WIN_B; i++) begin
      fv[i] = rnd ? int'($urandom_range(0, 7)) : 7;
      for (int k = 0; k < NCH; k++) gv[i][k] = rnd ? int'($urandom_range(0, 7)) : 7;
    end
    model(WIN_B, place, bp, bs);
    @(posedge clk); #1;
    b_start = 1'b1;
    b_place = PW'(place);
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < WIN_B; i++) begin
      b_valid = 1'b1;
      b_f     = DW'(fv[i]);
      for (int k = 0; k < NCH; k++) b_g[k*DW +: DW] = DW'(gv[i][k]);
      if (i == WIN_B - 1) begin
        e.place = bp; e.score = bs; e.t = cyc;
        qb.push_back(e);
      end
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    for (int w = 0; w < 20 && qb.size() != 0; w++) begin @(posedge clk); #1; end
    chk("b_done_seen", qb.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("b_idle_busy", b_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst = 1'b1;
    a_start = 1'b0; a_valid = 1'b0; a_place = '0; a_f = '0; a_g = '0;
    b_start = 1'b0; b_valid = 1'b0; b_place = '0; b_f = '0; b_g = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_place", a_bp, 0);
    chk("rst_a_score", $signed(a_bs), 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;

    // Scoring: scores 20, 0, -20, 34 -> channel 3
    set_scoring_data();
    a_window(10, 0, 1'b0);

    // Tie: every channel equals f
    for (int i = 0; i < WIN_A; i++)
      for (int k = 0; k < NCH; k++) gv[i][k] = fv[i];
    a_window(10, 0, 1'b0);

    // Stalls plus place wrap-around
    set_scoring_data();
    a_window(254, 2, 1'b0);

    // startsig during ACC, EVAL and DONE is ignored
    a_window(10, 0, 1'b1);

    // Reset halfway through a window
    @(posedge clk); #1;
    a_start = 1'b1; a_place = 8'd10;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'b1;
      a_f     = DW'(fv[i]);
      for (int k = 0; k < NCH; k++) a_g[k*DW +: DW] = DW'(gv[i][k]);
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    rst = 1'b1;
    d0 = done_a;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_place", a_bp, 0);
    chk("midrst_score", $signed(a_bs), 0);
    repeat (12) begin @(posedge clk); #1; end
    chk("midrst_no_done", done_a - d0, 0);
    held_place_a = 0;
    held_score_a = 0;
    a_window(10, 0, 1'b0);

    // Random windows on the short instance
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < WIN_A; i++) begin
        fv[i] = int'($urandom_range(0, 7));
        for (int k = 0; k < NCH; k++) gv[i][k] = int'($urandom_range(0, 7));
      end
      a_window(int'($urandom_range(0, 255)), r % 2, 1'b0);
    end

    // Full-range window at default parameters, then a random one
    b_window(77, 1'b0);
    b_window(int'($urandom_range(0, 255)), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
